// File: rtl/wbu_pipe.sv
// Write-back stage: holds one retiring instruction, formats its result and
// drives the register-file write port and the retired-instruction counter.
module wbu_pipe #(
  parameter  int XLEN  = 32,
  parameter  int RA_W  = 5,
  parameter  int CNT_W = 64,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [RA_W-1:0]  i_rd_addr,
  input  logic             i_rd_wen,
  input  logic [1:0]       i_src_sel,
  input  logic [XLEN-1:0]  i_exu_res,
  input  logic [XLEN-1:0]  i_lsu_res,
  input  logic [XLEN-1:0]  i_csr_res,
  input  logic [1:0]       i_ld_size,
  input  logic             i_ld_uns,
  input  logic [OFF_W-1:0] i_ld_off,
  input  logic             i_flush,
  input  logic             i_commit_ready,
  output logic             o_commit_valid,
  output logic [XLEN-1:0]  o_commit_pc,
  output logic             o_rf_wen,
  output logic [RA_W-1:0]  o_rf_waddr,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic [CNT_W-1:0] o_instret
);

  logic             vld_q;
  logic [XLEN-1:0]  pc_q;
  logic [RA_W-1:0]  rd_q;
  logic             wen_q;
  logic [XLEN-1:0]  data_q;
  logic [CNT_W-1:0] instret_q;

  logic             accept;
  logic             fire;
  logic [XLEN-1:0]  data_sel;

  // Align the addressed bytes to bit 0, then push the field to the top and
  // shift back down so the extension falls out of a logical/arithmetic shift.
  // A size wider than XLEN (dword on RV32) collapses to the full word.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0]  raw,
    input logic [1:0]       size,
    input logic             uns,
    input logic [OFF_W-1:0] off
  );
    logic [XLEN-1:0]        shifted;
    logic [XLEN-1:0]        left;
    logic signed [XLEN-1:0] left_s;
    int                     pad;
    shifted = raw >> {off, 3'b000};
    case (size)
      2'd0:    pad = XLEN - 8;
      2'd1:    pad = XLEN - 16;
      2'd2:    pad = XLEN - 32;
      default: pad = 0;
    endcase
    left   = shifted << pad;
    left_s = $signed(left);
    return uns ? (left >> pad) : $unsigned(left_s >>> pad);
  endfunction

  assign o_pre_ready = !i_flush && (!vld_q || i_commit_ready);
  assign accept      = i_pre_valid && o_pre_ready;
  // Reset outranks commit, so a held entry never writes during the reset cycle.
  assign fire        = vld_q && i_commit_ready && !i_flush && i_rst_n;

  always_comb begin
    data_sel = i_exu_res;
    case (i_src_sel)
      2'd0:    data_sel = i_exu_res;
      2'd1:    data_sel = fmt_load(i_lsu_res, i_ld_size, i_ld_uns, i_ld_off);
      2'd2:    data_sel = i_csr_res;
      default: data_sel = i_pc + XLEN'(4);
    endcase
  end

  // ---- capture stage: single held entry ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q     <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      if (i_flush) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        vld_q  <= 1'b1;
        pc_q   <= i_pc;
        rd_q   <= i_rd_addr;
        wen_q  <= i_rd_wen;
        data_q <= data_sel;
      end else if (fire) begin
        vld_q <= 1'b0;
      end
      if (fire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // ---- retire outputs ----
  assign o_commit_valid = vld_q;
  assign o_commit_pc    = pc_q;
  assign o_rf_waddr     = rd_q;
  assign o_rf_wdata     = data_q;
  assign o_rf_wen       = fire && wen_q && (rd_q != '0);
  assign o_instret      = instret_q;

endmodule
